// File: rtl/ntt_shuffle_ctrl_if.sv
// ntt_shuffle_ctrl_if: mode type plus the sequencer/buffer/memory signal bundle
// of the NTT shuffle controller.
package ntt_shuffle_pkg;
    typedef enum logic {CT = 1'b0, GS = 1'b1} mode_t;
endpackage

interface ntt_shuffle_ctrl_if #(
    parameter int ADDR_W = 15
);
    import ntt_shuffle_pkg::*;
    logic              zeroize;
    mode_t             mode;
    logic              shuffle_en;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        rand_chunk;
    logic [1:0]        rand_idx;
    logic              wren;
    logic [1:0]        wrptr;
    logic              rden;
    logic [1:0]        rdptr;
    logic              wr_rst_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_addr_vld;
    logic              busy;
    logic              done;

    modport slave (
        input  zeroize, mode, shuffle_en, start, base_addr, rand_chunk, rand_idx,
        output wren, wrptr, rden, rdptr, wr_rst_count, mem_addr, mem_addr_vld, busy, done
    );
    modport master (
        output zeroize, mode, shuffle_en, start, base_addr, rand_chunk, rand_idx,
        input  wren, wrptr, rden, rdptr, wr_rst_count, mem_addr, mem_addr_vld, busy, done
    );
endinterface

// File: rtl/ntt_shuffle_ctrl.sv
// ntt_shuffle_ctrl: per-pass sequencer for the NTT shuffle buffer, randomizing
// chunk order and in-chunk start index.
module ntt_shuffle_ctrl
    import ntt_shuffle_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int CHUNKS     = 16,
    parameter int MEM_RD_LAT = 1
) (
    input logic               clk,
    input logic               reset_n,
    ntt_shuffle_ctrl_if.slave ctrl_if
);
    localparam int CW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int JW  = CW + 2;
    localparam int LAT = (MEM_RD_LAT > 0) ? MEM_RD_LAT : 1;
    localparam int NIW = 2 * LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        mode_t               mode;
        logic                shuf;
        logic [ADDR_W-1:0]   base;
        logic [CW-1:0]       rc;
        logic [JW-1:0]       j;
        logic [CW-1:0]       rk;
        logic [LAT-1:0]      nv;
        logic [LAT-1:0][1:0] ni;
        logic [4:0]          rv;
        logic [4:0][1:0]     ri;
        logic [1:0][1:0]     fifo;
        logic                wp;
        logic                rp;
    } dp_t;

    state_t state_q, state_d;
    dp_t    dp_q, dp_d;

    function automatic logic [CW-1:0] chunk_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= (CW+1)'(CHUNKS)) ? CW'(s - (CW+1)'(CHUNKS)) : CW'(s);
    endfunction

    logic          accept, issue, gs, wv, rd_v, push, pop, last_rd;
    logic [1:0]    wi, ri, idx_m, wr_off;
    logic [CW-1:0] wch, rch;

    assign accept  = (state_q == IDLE) && ctrl_if.start && !ctrl_if.zeroize;
    assign issue   = state_q == ISSUE;
    assign gs      = dp_q.mode == GS;
    // NTT writes trail the address stream by the memory latency; INTT writes are immediate
    assign wv      = gs ? issue : dp_q.nv[LAT-1];
    assign wi      = gs ? dp_q.j[1:0] : dp_q.ni[LAT-1];
    // shuffled NTT reads need one extra cycle to resolve the permuted column
    assign rd_v    = (!gs && dp_q.shuf) ? dp_q.rv[4] : dp_q.rv[3];
    assign ri      = (!gs && dp_q.shuf) ? dp_q.ri[4] : dp_q.ri[3];
    assign idx_m   = dp_q.shuf ? ctrl_if.rand_idx : 2'b0;
    assign push    = wv && (wi == 2'd0);
    assign pop     = rd_v && (ri == 2'd3);
    assign last_rd = pop && (dp_q.rk == CW'(CHUNKS - 1));
    // the offset for a chunk's first write is taken live; later writes reuse the newest FIFO entry
    assign wr_off  = (wi == 2'd0) ? idx_m : dp_q.fifo[~dp_q.wp];
    assign wch     = chunk_add(dp_q.rc, dp_q.j[JW-1:2]);
    assign rch     = chunk_add(dp_q.rc, dp_q.rk);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = (dp_q.j == JW'(4*CHUNKS - 1)) ? DRAIN : ISSUE;
            DRAIN:   state_d = last_rd ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (ctrl_if.zeroize) state_d = IDLE;
    end

    always_comb begin
        dp_d = dp_q;
        if (accept) begin
            dp_d.mode = ctrl_if.mode;
            dp_d.shuf = ctrl_if.shuffle_en;
            dp_d.base = ctrl_if.base_addr;
            dp_d.rc   = ctrl_if.shuffle_en ? CW'(32'(ctrl_if.rand_chunk) % CHUNKS) : '0;
            dp_d.j    = '0;
            dp_d.rk   = '0;
        end
        if (issue) dp_d.j = dp_q.j + 1'b1;
        dp_d.nv = LAT'({dp_q.nv, issue});
        dp_d.ni = NIW'({dp_q.ni, dp_q.j[1:0]});
        dp_d.rv = {dp_q.rv[3:0], wv};
        dp_d.ri = {dp_q.ri[3:0], wi};
        if (push) begin
            dp_d.fifo[dp_q.wp] = idx_m;
            dp_d.wp            = ~dp_q.wp;
        end
        if (pop) begin
            dp_d.rp = ~dp_q.rp;
            dp_d.rk = dp_q.rk + 1'b1;
        end
        if (ctrl_if.zeroize) dp_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            dp_q    <= dp_d;
        end
    end

    assign ctrl_if.wren         = wv;
    assign ctrl_if.wrptr        = wv ? (gs ? wi + wr_off : wi) : 2'b0;
    assign ctrl_if.rden         = rd_v;
    assign ctrl_if.rdptr        = rd_v ? (gs ? ri : ri + dp_q.fifo[dp_q.rp]) : 2'b0;
    assign ctrl_if.wr_rst_count = accept;
    assign ctrl_if.mem_addr_vld = gs ? rd_v : issue;
    assign ctrl_if.mem_addr     = gs ? (rd_v ? dp_q.base + ADDR_W'({rch, ri}) : '0)
                                     : (issue ? dp_q.base + ADDR_W'({wch, dp_q.j[1:0]}) : '0);
    assign ctrl_if.busy         = state_q != IDLE;
    assign ctrl_if.done         = state_q == DONE;
endmodule
